// File: rtl/rr_pkg.sv
// Shared definitions for the register-read stage.
// Instruction format encoding seen by reg_read_pipe.
package rr_pkg;

  typedef enum logic [1:0] {
    FMT_NONE = 2'b00,
    FMT_J    = 2'b01,
    FMT_I    = 2'b10,
    FMT_R    = 2'b11
  } fmt_e;

endpackage

// File: rtl/reg_read_pipe_rf.sv
// Register file: three bypassed read ports, one write port.
// Reset loads R[i] = (i+1) mod NREG.
module reg_read_pipe_rf #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int IDX_W  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ra,
  input  logic [IDX_W-1:0]  rb,
  input  logic [IDX_W-1:0]  rc,
  output logic [DATA_W-1:0] da,
  output logic [DATA_W-1:0] db,
  output logic [DATA_W-1:0] dc
);

  logic [DATA_W-1:0] r [NREG];

  // Reset seeds each entry; otherwise accept the write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        r[i] <= DATA_W'((i + 1) % NREG);
    end else if (we) begin
      r[widx] <= wdata;
    end
  end

  // Same-cycle write is forwarded to the readers.
  always_comb begin
    da = (we && widx == ra) ? wdata : r[ra];
    db = (we && widx == rb) ? wdata : r[rb];
    dc = (we && widx == rc) ? wdata : r[rc];
  end

endmodule

// File: rtl/reg_read_pipe.sv
// Register-read pipeline stage: operand fetch,
// format mux and a one-entry valid/ready output register.
module reg_read_pipe
  import rr_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int IMM_W    = 9,
  parameter int CTRL_W   = 7,
  parameter int SIGN_EXT = 0,
  parameter int IDX_W    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [IDX_W-1:0]  in_ra,
  input  logic [IDX_W-1:0]  in_rb,
  input  logic [IDX_W-1:0]  in_rc,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              wb_en,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        out_fmt,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  input  logic              out_ready
);

  logic [DATA_W-1:0] rd_a, rd_b, rd_c;
  logic [DATA_W-1:0] imm_x, b_n, c_n;
  logic              accept;

  reg_read_pipe_rf #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .IDX_W  (IDX_W)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (wb_en),
    .widx  (wb_idx),
    .wdata (wb_data),
    .ra    (in_ra),
    .rb    (in_rb),
    .rc    (in_rc),
    .da    (rd_a),
    .db    (rd_b),
    .dc    (rd_c)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Immediate widening and per-format operand selection.
  always_comb begin
    if (SIGN_EXT != 0)
      imm_x = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    else
      imm_x = {{(DATA_W-IMM_W){1'b0}}, in_imm};
    b_n = '0;
    c_n = '0;
    unique case (1'b1)
      in_fmt == FMT_R: begin
        b_n = rd_b;
        c_n = rd_c;
      end
      in_fmt == FMT_I: begin
        b_n = rd_b;
        c_n = imm_x;
      end
      in_fmt == FMT_J: c_n = imm_x;
      default: ;
    endcase
  end

  // Output register: reset > flush > capture > drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_fmt   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_fmt   <= in_fmt;
      out_a     <= rd_a;
      out_b     <= b_n;
      out_c     <= c_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_pipe.sv
// Bench for reg_read_pipe: directed table, corner
// sequences and random traffic against a reference model.
module tb_reg_read_pipe;
  import rr_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, wb_en;
  logic [1:0]  in_fmt;
  logic [6:0]  in_ctrl;
  logic [2:0]  in_ra, in_rb, in_rc, wb_idx;
  logic [8:0]  in_imm;
  logic [15:0] wb_data;
  logic        in_ready, out_valid;
  logic [6:0]  out_ctrl;
  logic [1:0]  out_fmt;
  logic [15:0] out_a, out_b, out_c;
  logic        s_in_ready, s_out_valid;
  logic [6:0]  s_out_ctrl;
  logic [1:0]  s_out_fmt;
  logic [15:0] s_out_a, s_out_b, s_out_c;

  int checks = 0;
  int errors = 0;

  logic [15:0] mr [8];
  logic        mv;
  logic [15:0] ma, mb, mc, mcx;
  logic [6:0]  mctrl;
  logic [1:0]  mfmt;

  always #5 clk = ~clk;

  reg_read_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_ctrl(in_ctrl),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
    .in_imm(in_imm), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(out_valid), .out_ctrl(out_ctrl),
    .out_fmt(out_fmt), .out_a(out_a),
    .out_b(out_b), .out_c(out_c),
    .out_ready(out_ready)
  );

  reg_read_pipe #(.SIGN_EXT(1)) dut_sx (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_ctrl(in_ctrl),
    .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
    .in_imm(in_imm), .wb_en(wb_en),
    .wb_idx(wb_idx), .wb_data(wb_data),
    .out_valid(s_out_valid), .out_ctrl(s_out_ctrl),
    .out_fmt(s_out_fmt), .out_a(s_out_a),
    .out_b(s_out_b), .out_c(s_out_c),
    .out_ready(out_ready)
  );

  task automatic chk(string n, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(logic [2:0] i);
    return (wb_en && wb_idx == i) ? wb_data : mr[i];
  endfunction

  // One clock with the current inputs; model and DUT compared.
  task automatic tick();
    logic        rdy, acc;
    logic [15:0] va, vb, vc, ze, se;
    #1;
    rdy = !mv || out_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    acc = in_valid && rdy;
    va = rd(in_ra);
    vb = rd(in_rb);
    vc = rd(in_rc);
    ze = {7'b0, in_imm};
    se = {{7{in_imm[8]}}, in_imm};
    @(posedge clk);
    #1;
    if (reset) begin
      mv = 0; ma = 0; mb = 0; mc = 0; mcx = 0;
      mctrl = 0; mfmt = 0;
      for (int i = 0; i < 8; i++) mr[i] = 16'((i + 1) % 8);
    end else begin
      if (flush) mv = 0;
      else if (acc) begin
        mv = 1; ma = va; mctrl = in_ctrl; mfmt = in_fmt;
        mb = 0; mc = 0; mcx = 0;
        if (in_fmt == FMT_R) begin
          mb = vb; mc = vc; mcx = vc;
        end else if (in_fmt == FMT_I) begin
          mb = vb; mc = ze; mcx = se;
        end else if (in_fmt == FMT_J) begin
          mc = ze; mcx = se;
        end
      end else if (out_ready) mv = 0;
      if (wb_en) mr[wb_idx] = wb_data;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    chk("out_a", {16'b0, out_a}, {16'b0, ma});
    chk("out_b", {16'b0, out_b}, {16'b0, mb});
    chk("out_c", {16'b0, out_c}, {16'b0, mc});
    chk("ctrl_fmt", {23'b0, out_ctrl, out_fmt},
        {23'b0, mctrl, mfmt});
    chk("sx_out_c", {16'b0, s_out_c}, {16'b0, mcx});
  endtask

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; out_ready = 1;
    wb_en = 0; wb_idx = 0; wb_data = 0;
    in_fmt = 0; in_ctrl = 0; in_imm = 0;
    in_ra = 0; in_rb = 0; in_rc = 0;
  endtask

  task automatic op(logic [1:0] f, logic [2:0] a,
                    logic [2:0] b, logic [2:0] c,
                    logic [8:0] im, logic [6:0] ct);
    in_valid = 1; in_fmt = f; in_ra = a; in_rb = b;
    in_rc = c; in_imm = im; in_ctrl = ct;
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [2:0]  ra, rb, rc;
    logic [8:0]  imm;
    logic [15:0] a, b, c, cx;
  } vec_t;

  vec_t tv [5];

  initial begin
    tv[0] = '{FMT_R, 3'd0, 3'd1, 3'd6, 9'h000,
              16'd1, 16'd2, 16'd7, 16'd7};
    tv[1] = '{FMT_I, 3'd0, 3'd3, 3'd0, 9'h1F0,
              16'd1, 16'd4, 16'h01F0, 16'hFFF0};
    tv[2] = '{FMT_J, 3'd7, 3'd3, 3'd0, 9'h1F0,
              16'd0, 16'd0, 16'h01F0, 16'hFFF0};
    tv[3] = '{FMT_NONE, 3'd4, 3'd1, 3'd2, 9'h0FF,
              16'd5, 16'd0, 16'd0, 16'd0};
    tv[4] = '{FMT_I, 3'd1, 3'd5, 3'd0, 9'h0FF,
              16'd2, 16'd6, 16'h00FF, 16'h00FF};
    mv = 0; ma = 0; mb = 0; mc = 0; mcx = 0;
    mctrl = 0; mfmt = 0;
    for (int i = 0; i < 8; i++) mr[i] = 0;

    idle();
    reset = 1;
    in_valid = 1; wb_en = 1; wb_idx = 0; wb_data = 16'hDEAD;
    tick();
    idle();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", {16'b0, out_a}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      op(tv[i].fmt, tv[i].ra, tv[i].rb, tv[i].rc,
         tv[i].imm, 7'(i + 1));
      tick();
      chk("tv_a", {16'b0, out_a}, {16'b0, tv[i].a});
      chk("tv_b", {16'b0, out_b}, {16'b0, tv[i].b});
      chk("tv_c", {16'b0, out_c}, {16'b0, tv[i].c});
      chk("tv_cx", {16'b0, s_out_c}, {16'b0, tv[i].cx});
    end

    idle();
    op(FMT_R, 3'd2, 3'd2, 3'd0, 9'd0, 7'h11);
    wb_en = 1; wb_idx = 2; wb_data = 16'hABCD;
    tick();
    chk("byp_a", {16'b0, out_a}, 32'hABCD);
    chk("byp_b", {16'b0, out_b}, 32'hABCD);
    idle();
    op(FMT_R, 3'd2, 3'd0, 3'd0, 9'd0, 7'h12);
    tick();
    chk("byp_later", {16'b0, out_a}, 32'hABCD);

    idle();
    op(FMT_R, 3'd3, 3'd4, 3'd5, 9'd0, 7'h21);
    tick();
    chk("stall_first", {16'b0, out_a}, 32'd4);
    op(FMT_R, 3'd3, 3'd0, 3'd0, 9'd0, 7'h22);
    out_ready = 0;
    wb_en = 1; wb_idx = 3; wb_data = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rdy", {31'b0, in_ready}, 32'd0);
      tick();
      wb_en = 0;
      chk("stall_a", {16'b0, out_a}, 32'd4);
      chk("stall_ctrl", {25'b0, out_ctrl}, 32'h21);
    end
    out_ready = 1;
    tick();
    chk("stall_next", {16'b0, out_a}, 32'h1234);
    chk("stall_nctl", {25'b0, out_ctrl}, 32'h22);

    idle();
    op(FMT_R, 3'd5, 3'd0, 3'd0, 9'd0, 7'h31);
    flush = 1;
    wb_en = 1; wb_idx = 5; wb_data = 16'h5555;
    tick();
    chk("flush_v", {31'b0, out_valid}, 32'd0);
    idle();
    op(FMT_R, 3'd5, 3'd0, 3'd0, 9'd0, 7'h32);
    tick();
    chk("flush_r5", {16'b0, out_a}, 32'h5555);

    idle();
    op(FMT_R, 3'd0, 3'd0, 3'd0, 9'd0, 7'h41);
    tick();
    out_ready = 0;
    tick();
    reset = 1;
    wb_en = 1; wb_idx = 0; wb_data = 16'hFFFF;
    tick();
    chk("rstall_v", {31'b0, out_valid}, 32'd0);
    chk("rstall_a", {16'b0, out_a}, 32'd0);
    idle();
    op(FMT_R, 3'd2, 3'd5, 3'd3, 9'd0, 7'h42);
    tick();
    chk("rinit_a", {16'b0, out_a}, 32'd3);
    chk("rinit_b", {16'b0, out_b}, 32'd6);
    chk("rinit_c", {16'b0, out_c}, 32'd4);
    idle();
    op(FMT_R, 3'd0, 3'd7, 3'd6, 9'd0, 7'h43);
    tick();
    chk("rinit_r0", {16'b0, out_a}, 32'd1);
    chk("rinit_r7", {16'b0, out_b}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom % 60) == 0;
      flush = ($urandom % 10) == 0;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      wb_en = ($urandom % 2) == 0;
      wb_idx = 3'($urandom);
      wb_data = 16'($urandom);
      in_fmt = 2'($urandom);
      in_ctrl = 7'($urandom);
      in_ra = 3'($urandom);
      in_rb = 3'($urandom);
      in_rc = 3'($urandom);
      in_imm = 9'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_read_pipe.md
REG_READ_PIPE -- requirements
Module: reg_read_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and operand width.
REQ-002 SHALL have parameter NREG, default 8, register count (power of two, >=2); IDX_W = log2(NREG).
REQ-003 SHALL have parameter IMM_W, default 9, immediate width (< DATA_W).
REQ-004 SHALL have parameter CTRL_W, default 7, pass-through control width.
REQ-005 SHALL have parameter SIGN_EXT, default 0, immediate extension (0 zero, 1 sign).
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports flush (input, 1, drop stage contents), in_valid (input, 1), in_ready (output, 1).
REQ-009 SHALL have inputs in_fmt (2; 11 R, 10 I, 01 J, 00 none), in_ctrl (CTRL_W), in_ra/in_rb/in_rc (IDX_W each), in_imm (IMM_W).
REQ-010 SHALL have inputs wb_en (1), wb_idx (IDX_W), wb_data (DATA_W), the write-back port.
REQ-011 SHALL have outputs out_valid (1), out_ctrl (CTRL_W), out_fmt (2), out_a/out_b/out_c (DATA_W each), and input out_ready (1).

Function
REQ-012 SHALL accept an input when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-013 SHALL present an accepted input on the outputs 1 cycle later with out_valid=1.
REQ-014 SHALL set out_a = R[in_ra] for every format.
REQ-015 SHALL set, for fmt R: out_b=R[in_rb], out_c=R[in_rc].
REQ-016 SHALL set, for fmt I: out_b=R[in_rb], out_c=ext(in_imm).
REQ-017 SHALL set, for fmt J: out_b=0, out_c=ext(in_imm).
REQ-018 SHALL set, for fmt none: out_b=0, out_c=0.
REQ-019 SHALL extend the immediate to DATA_W by zero-extension (SIGN_EXT=0) or sign-extension from bit IMM_W-1 (SIGN_EXT=1).
REQ-020 SHALL pass in_ctrl and in_fmt unchanged to out_ctrl and out_fmt.
REQ-021 SHALL write wb_data into R[wb_idx] on every cycle with wb_en=1, regardless of stall, flush or in_valid.
REQ-022 SHALL bypass the write: a read of wb_idx in the same cycle as wb_en=1 returns wb_data, not the old value.
REQ-023 SHALL hold all output fields stable while out_valid && !out_ready; held operands are not refreshed by later writes.
REQ-024 SHALL, when out_valid && out_ready and no new input is accepted, clear out_valid next cycle; data fields keep their last values.
REQ-025 SHALL, when flush=1, clear out_valid next cycle and discard any input accepted in that cycle; in_ready still follows REQ-012.
REQ-026 SHALL give reset priority over flush, and flush priority over capture.
REQ-027 SHALL support back-to-back transfers: one result per cycle while in_valid=out_ready=1.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, set out_valid=0 and out_a/out_b/out_c/out_ctrl/out_fmt=0.
REQ-029 SHALL, on reset, load R[i] = (i+1) mod NREG (defaults: R0=1 … R6=7, R7=0).
REQ-030 SHALL ignore wb_en and in_valid in a reset cycle; reset mid-stall drops the held result.

Structure
REQ-031 SHALL take the fmt encoding (FMT_R/FMT_I/FMT_J/FMT_NONE) from the shared package rr_pkg.
REQ-032 SHALL instantiate one sub-module, reg_read_pipe_rf: NREG x DATA_W, 3 read ports with bypass, 1 write port, reset initialisation.
REQ-033 SHALL keep the handshake, format mux and output register in reg_read_pipe.

Verification (defaults, SIGN_EXT=0 unless stated)
REQ-034 SHALL check reset then idle: out_valid=0, all outputs 0; then fmt R, ra=0, rb=1, rc=6 -> next cycle out_a=1, out_b=2, out_c=7.
REQ-035 SHALL check the immediates: fmt I, rb=3, imm=9'h1F0 -> out_b=4, out_c=16'h01F0; with SIGN_EXT=1 -> out_c=16'hFFF0; fmt J -> out_b=0.
REQ-036 SHALL check the bypass: wb_en=1, wb_idx=2, wb_data=16'hABCD with fmt R, ra=2 in the same cycle -> out_a=16'hABCD; a later read of R2 also returns 16'hABCD.
REQ-037 SHALL check the stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, a write to a held source register is not visible; out_ready=1 -> the next input is accepted.
REQ-038 SHALL check flush together with accept and wb_en=1, wb_idx=5 -> out_valid=0 next cycle, R5 updated.
REQ-039 SHALL check reset asserted during a stall -> out_valid=0 and R restored to its initial values.
